// File: rtl/btb_update_queue_pkg.sv
// Shared fetch-unit types for the BTB update path: branch results, BTB entries,
// queue entries and the address-to-BTB-field helpers.
package btb_update_queue_pkg;

  localparam int ADDR_WIDTH         = 32;
  localparam int INSN_OFFSET        = 2;
  localparam int INT_ISSUE_WIDTH    = 2;
  localparam int FETCH_WIDTH        = 4;
  localparam int BTB_ENTRY_NUM      = 1024;
  localparam int BTB_INDEX_WIDTH    = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_TAG_WIDTH      = 8;
  localparam int BTB_ADDR_WIDTH     = ADDR_WIDTH - INSN_OFFSET;
  localparam int BTB_QUEUE_SIZE     = 32;
  localparam int BTB_BANK_BIT_WIDTH = $clog2(FETCH_WIDTH);

  typedef logic [ADDR_WIDTH-1:0]              AddrPath;
  typedef logic [BTB_INDEX_WIDTH-1:0]         BTB_IndexPath;
  typedef logic [BTB_TAG_WIDTH-1:0]           BTB_TagPath;
  typedef logic [BTB_ADDR_WIDTH-1:0]          BTB_AddrPath;
  typedef logic [$clog2(BTB_QUEUE_SIZE)-1:0]  BTBQueuePointerPath;

  typedef struct packed {
    logic    valid;
    logic    execTaken;
    AddrPath brAddr;
    AddrPath nextAddr;
    logic    isCondBr;
    logic    isRASPushBr;
    logic    isRASPopBr;
  } BranchResult;

  typedef struct packed {
    logic        valid;
    BTB_TagPath  tag;
    BTB_AddrPath data;
    logic        isCondBr;
    logic        isRASPushBr;
    logic        isRASPopBr;
  } BTB_Entry;

  typedef struct packed {
    AddrPath  wa;
    BTB_Entry wv;
  } BTBQueueEntry;

  function automatic BTB_IndexPath ToBTB_Index(AddrPath addr);
    return addr[INSN_OFFSET +: BTB_INDEX_WIDTH];
  endfunction

  function automatic BTB_TagPath ToBTB_Tag(AddrPath addr);
    return addr[INSN_OFFSET + BTB_INDEX_WIDTH +: BTB_TAG_WIDTH];
  endfunction

  function automatic BTB_AddrPath ToBTB_Addr(AddrPath addr);
    return addr[INSN_OFFSET +: BTB_ADDR_WIDTH];
  endfunction

  // Same bank when the low bank-select bits of the two indices match.
  function automatic logic IsBTB_BankConflict(BTB_IndexPath a, BTB_IndexPath b);
    return a[BTB_BANK_BIT_WIDTH-1:0] == b[BTB_BANK_BIT_WIDTH-1:0];
  endfunction

  function automatic BTBQueueEntry MakeBTBQueueEntry(BranchResult br);
    BTBQueueEntry e;
    e.wa             = br.brAddr;
    e.wv.valid       = 1'b1;
    e.wv.tag         = ToBTB_Tag(br.brAddr);
    e.wv.data        = ToBTB_Addr(br.nextAddr);
    e.wv.isCondBr    = br.isCondBr;
    e.wv.isRASPushBr = br.isRASPushBr;
    e.wv.isRASPopBr  = br.isRASPopBr;
    return e;
  endfunction

endpackage

// File: rtl/btb_update_queue_if.sv
// Bundle between integer execute / fetch-side BTB read and the BTB update queue.
interface btb_update_queue_if
  import btb_update_queue_pkg::*;
#(
  parameter int UPDATE_WIDTH = INT_ISSUE_WIDTH
);
  BranchResult  brResult [UPDATE_WIDTH];
  logic         fetchRE;
  BTB_IndexPath fetchIndex;
  logic         btbWE;
  BTB_IndexPath btbWA;
  BTB_Entry     btbWV;
  logic         full;
  logic         overflow;

  modport master (
    output brResult, fetchRE, fetchIndex,
    input  btbWE, btbWA, btbWV, full, overflow
  );

  modport slave (
    input  brResult, fetchRE, fetchIndex,
    output btbWE, btbWA, btbWV, full, overflow
  );
endinterface

// File: rtl/btb_update_queue_storage.sv
// Queue RAM: one write port per update lane, one asynchronous read port for the head.
// Contents are never reset; the pointer logic keeps stale slots unreachable.
module btb_update_queue_storage
  import btb_update_queue_pkg::*;
#(
  parameter  int QUEUE_SIZE = BTB_QUEUE_SIZE,
  parameter  int WRITE_NUM  = INT_ISSUE_WIDTH,
  localparam int PTR_W      = $clog2(QUEUE_SIZE)
)(
  input  logic             clk,
  input  logic             we [WRITE_NUM],
  input  logic [PTR_W-1:0] wa [WRITE_NUM],
  input  BTBQueueEntry     wv [WRITE_NUM],
  input  logic [PTR_W-1:0] ra,
  output BTBQueueEntry     rv
);

  BTBQueueEntry mem [QUEUE_SIZE];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WRITE_NUM; i++) begin
      if (we[i]) mem[wa[i]] <= wv[i];
    end
  end

  assign rv = mem[ra];

endmodule

// File: rtl/btb_update_queue.sv
// Collects taken-branch results into a FIFO and writes them into the BTB one per
// cycle, holding the head back whenever the fetch-side read hits the same bank.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int UPDATE_WIDTH   = INT_ISSUE_WIDTH,
  parameter int QUEUE_SIZE     = BTB_QUEUE_SIZE,
  parameter int BANK_BIT_WIDTH = $clog2(FETCH_WIDTH)
)(
  input logic clk,
  input logic rst,
  btb_update_queue_if.slave bus
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] PtrPath;
  typedef logic [CNT_W-1:0] CountPath;

  PtrPath       head;
  PtrPath       tail;
  CountPath     count;

  logic         laneWE [UPDATE_WIDTH];
  PtrPath       laneWA [UPDATE_WIDTH];
  BTBQueueEntry laneWV [UPDATE_WIDTH];

  BTBQueueEntry headEntry;
  BTB_IndexPath headIndex;
  logic         conflict;
  logic         deq;
  logic         dropped;
  CountPath     capacity;
  CountPath     qualN;
  CountPath     enqN;

  btb_update_queue_storage #(
    .QUEUE_SIZE (QUEUE_SIZE),
    .WRITE_NUM  (UPDATE_WIDTH)
  ) storage (
    .clk (clk),
    .we  (laneWE),
    .wa  (laneWA),
    .wv  (laneWV),
    .ra  (head),
    .rv  (headEntry)
  );

  assign headIndex = ToBTB_Index(headEntry.wa);

  // A single-bank BTB collides with every read; otherwise compare bank-select bits.
  generate
    if (BANK_BIT_WIDTH == 0) begin : gNoBanks
      assign conflict = bus.fetchRE;
    end else if (BANK_BIT_WIDTH == BTB_BANK_BIT_WIDTH) begin : gDefaultBanks
      assign conflict = bus.fetchRE && IsBTB_BankConflict(headIndex, bus.fetchIndex);
    end else begin : gCustomBanks
      assign conflict = bus.fetchRE &&
        (headIndex[BANK_BIT_WIDTH-1:0] == bus.fetchIndex[BANK_BIT_WIDTH-1:0]);
    end
  endgenerate

  assign deq      = !rst && (count != '0) && !conflict;
  assign capacity = CountPath'(QUEUE_SIZE) - count + CountPath'(deq);

  // Compact qualifying lanes from lane 0 upward; anything past capacity is dropped,
  // and once one lane is dropped every later lane is too.
  always_comb begin
    qualN = '0;
    enqN  = '0;
    for (int i = 0; i < UPDATE_WIDTH; i++) begin
      laneWE[i] = 1'b0;
      laneWA[i] = tail + PtrPath'(enqN);
      laneWV[i] = MakeBTBQueueEntry(bus.brResult[i]);
      if (bus.brResult[i].valid && bus.brResult[i].execTaken) begin
        if (qualN < capacity) begin
          laneWE[i] = 1'b1;
          enqN      = enqN + CountPath'(1);
        end
        qualN = qualN + CountPath'(1);
      end
    end
    dropped = (qualN != enqN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= head + PtrPath'(1);
      tail  <= tail + PtrPath'(enqN);
      count <= count + enqN - CountPath'(deq);
    end
  end

  assign bus.btbWE    = deq;
  assign bus.btbWA    = deq ? headIndex : '0;
  assign bus.btbWV    = deq ? headEntry.wv : '0;
  assign bus.full     = !rst && ((CountPath'(QUEUE_SIZE) - count) < CountPath'(UPDATE_WIDTH));
  assign bus.overflow = !rst && dropped;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed and randomized checks of btb_update_queue against a queue-based model
// of the expected BTB write stream.
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  btb_update_queue_if #(.UPDATE_WIDTH(LANES)) bus();

  btb_update_queue #(
    .UPDATE_WIDTH   (LANES),
    .QUEUE_SIZE     (DEPTH),
    .BANK_BIT_WIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [9:0] idx;
    BTB_Entry   e;
  } ExpWrite;

  ExpWrite  expQ[$];
  ExpWrite  pending[$];
  int       checks = 0;
  int       errors = 0;
  logic     expWE;
  logic [9:0] expWA;
  BTB_Entry expWV;
  logic     expFull;
  logic     expOverflow;

  BranchResult idle;

  // Expected BTB write for one taken result, from the address arithmetic alone.
  function automatic ExpWrite makeExp(BranchResult br);
    ExpWrite w;
    w.idx           = 10'((br.brAddr / 4) % 1024);
    w.e.valid       = 1'b1;
    w.e.tag         = 8'((br.brAddr / 4096) % 256);
    w.e.data        = 30'(br.nextAddr / 4);
    w.e.isCondBr    = br.isCondBr;
    w.e.isRASPushBr = br.isRASPushBr;
    w.e.isRASPopBr  = br.isRASPopBr;
    return w;
  endfunction

  function automatic BranchResult mkBr(logic v, logic t, logic [31:0] a, logic [31:0] n, logic [2:0] f);
    BranchResult b;
    b.valid       = v;
    b.execTaken   = t;
    b.brAddr      = a;
    b.nextAddr    = n;
    b.isCondBr    = f[0];
    b.isRASPushBr = f[1];
    b.isRASPopBr  = f[2];
    return b;
  endfunction

  function automatic BranchResult randBr(int takenPct);
    return mkBr(1'($urandom_range(0, 1)) | 1'(takenPct >= 100),
                1'($urandom_range(0, 99) < takenPct),
                32'($urandom), 32'($urandom), 3'($urandom));
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input BranchResult l0, input BranchResult l1,
                               input logic re, input logic [9:0] fidx);
    bus.brResult[0] = l0;
    bus.brResult[1] = l1;
    bus.fetchRE     = re;
    bus.fetchIndex  = fidx;
  endtask

  // Predict this cycle's outputs from the model and compare against the DUT.
  task automatic checkOutput(input string tag);
    int nq;
    int cap;
    pending.delete();
    if (rst) begin
      expWE = 1'b0; expWA = '0; expWV = '0; expFull = 1'b0; expOverflow = 1'b0;
    end else begin
      expWE = 1'b0;
      if (expQ.size() > 0)
        expWE = !(bus.fetchRE && ((expQ[0].idx % 4) == (bus.fetchIndex % 4)));
      expWA = expWE ? expQ[0].idx : '0;
      expWV = expWE ? expQ[0].e : '0;
      cap = DEPTH - expQ.size() + (expWE ? 1 : 0);
      nq = 0;
      for (int i = 0; i < LANES; i++) begin
        if (bus.brResult[i].valid && bus.brResult[i].execTaken) begin
          if (nq < cap) pending.push_back(makeExp(bus.brResult[i]));
          nq++;
        end
      end
      expOverflow = (nq > cap);
      expFull     = (DEPTH - expQ.size()) < LANES;
    end
    checkEq({tag, ".we"},       64'(bus.btbWE),    64'(expWE));
    checkEq({tag, ".full"},     64'(bus.full),     64'(expFull));
    checkEq({tag, ".overflow"}, 64'(bus.overflow), 64'(expOverflow));
    if (expWE || rst) begin
      checkEq({tag, ".wa"}, 64'(bus.btbWA), 64'(expWA));
      checkEq({tag, ".wv"}, 64'(bus.btbWV), 64'(expWV));
    end
  endtask

  task automatic sampleCycle(input string tag);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) expQ.delete();
    else begin
      if (expWE) void'(expQ.pop_front());
      foreach (pending[i]) expQ.push_back(pending[i]);
    end
    #1;
  endtask

  task automatic stepCycle(input string tag);
    sampleCycle(tag);
    advance();
  endtask

  function automatic logic [31:0] fillAddr(int j);
    return 32'h2000_0000 + 32'(j * 16);
  endfunction

  initial begin
    idle = '0;
    rst = 1'b1;
    applyStimulus(idle, idle, 1'b0, '0);

    // Reset state
    sampleCycle("reset");
    checkEq("reset.weConst", 64'(bus.btbWE), 64'(0));
    advance();
    rst = 1'b0;

    // Single update: write appears the next cycle
    applyStimulus(mkBr(1, 1, 32'h1000_0040, 32'h1000_0100, 3'b001), idle, 1'b0, '0);
    stepCycle("single.enq");
    applyStimulus(idle, idle, 1'b0, '0);
    sampleCycle("single.wr");
    checkEq("single.weConst",    64'(bus.btbWE),       64'(1));
    checkEq("single.waConst",    64'(bus.btbWA),       64'(10'h010));
    checkEq("single.dataConst",  64'(bus.btbWV.data),  64'(30'h0400_0040));
    checkEq("single.validConst", 64'(bus.btbWV.valid), 64'(1));
    advance();

    // Not-taken results are filtered out
    applyStimulus(mkBr(1, 0, 32'h1000_0080, 32'h1000_0200, 3'b000), idle, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      sampleCycle("notTaken");
      checkEq("notTaken.weConst", 64'(bus.btbWE), 64'(0));
      advance();
    end

    // Bank conflict holds the head for exactly as long as it persists
    applyStimulus(mkBr(1, 1, 32'h1000_0040, 32'h1000_0300, 3'b010), idle, 1'b0, '0);
    stepCycle("conflict.enq");
    applyStimulus(idle, idle, 1'b1, 10'h004);
    for (int k = 0; k < 3; k++) begin
      sampleCycle("conflict.hold");
      checkEq("conflict.weConst", 64'(bus.btbWE), 64'(0));
      advance();
    end
    applyStimulus(idle, idle, 1'b1, 10'h005);
    sampleCycle("conflict.release");
    checkEq("conflict.releaseConst", 64'(bus.btbWE), 64'(1));
    advance();

    // Fill with the head blocked, overflow on the 17th pair, then drain in order
    for (int k = 0; k < 16; k++) begin
      applyStimulus(mkBr(1, 1, fillAddr(2*k), 32'($urandom), 3'($urandom)),
                    mkBr(1, 1, fillAddr(2*k+1), 32'($urandom), 3'($urandom)), 1'b1, 10'h000);
      stepCycle("fill");
    end
    applyStimulus(mkBr(1, 1, fillAddr(40), 32'h0, 3'b0),
                  mkBr(1, 1, fillAddr(41), 32'h4, 3'b0), 1'b1, 10'h000);
    sampleCycle("fill.overflow");
    checkEq("fill.fullConst",     64'(bus.full),     64'(1));
    checkEq("fill.overflowConst", 64'(bus.overflow), 64'(1));
    advance();
    applyStimulus(idle, idle, 1'b0, '0);
    for (int k = 0; k < 32; k++) begin
      sampleCycle("drain");
      checkEq("drain.waConst", 64'(bus.btbWA), 64'(10'(k * 4)));
      advance();
    end
    sampleCycle("drain.empty");
    checkEq("drain.emptyConst", 64'(bus.btbWE), 64'(0));
    advance();
    applyStimulus(mkBr(1, 1, 32'h3000_0010, 32'h3000_1000, 3'b100),
                  mkBr(1, 1, 32'h3000_0020, 32'h3000_2000, 3'b001), 1'b0, '0);
    stepCycle("wrap.enq");
    applyStimulus(idle, idle, 1'b0, '0);
    stepCycle("wrap.wr0");
    stepCycle("wrap.wr1");

    // Enqueue two while the head drains at count 31
    for (int k = 0; k < 16; k++) begin
      applyStimulus(mkBr(1, 1, fillAddr(2*k), 32'($urandom), 3'($urandom)),
                    mkBr(k < 15, 1, fillAddr(2*k+1), 32'($urandom), 3'($urandom)), 1'b1, 10'h000);
      stepCycle("fill31");
    end
    applyStimulus(mkBr(1, 1, fillAddr(50), 32'h0, 3'b0),
                  mkBr(1, 1, fillAddr(51), 32'h4, 3'b0), 1'b0, '0);
    sampleCycle("enqDeq31");
    checkEq("enqDeq31.overflowConst", 64'(bus.overflow), 64'(0));
    checkEq("enqDeq31.weConst",       64'(bus.btbWE),    64'(1));
    advance();
    applyStimulus(idle, idle, 1'b1, 10'h000);
    sampleCycle("enqDeq31.at32");
    checkEq("enqDeq31.fullConst", 64'(bus.full), 64'(1));
    advance();
    applyStimulus(idle, idle, 1'b0, '0);
    for (int k = 0; k < 33; k++) stepCycle("drain32");

    // Randomized traffic: light, then heavy enough to fill and overflow
    for (int k = 0; k < 300; k++) begin
      applyStimulus(randBr(75), randBr(75), 1'($urandom_range(0, 1)), 10'($urandom));
      stepCycle("randLight");
    end
    for (int k = 0; k < 200; k++) begin
      applyStimulus(randBr(100), randBr(90), 1'b1, 10'($urandom));
      stepCycle("randHeavy");
    end
    applyStimulus(idle, idle, 1'b0, '0);
    for (int k = 0; k < 40; k++) stepCycle("randDrain");

    // Asynchronous reset in the middle of a drain discards everything
    for (int k = 0; k < 5; k++) begin
      applyStimulus(mkBr(1, 1, fillAddr(2*k), 32'($urandom), 3'b0),
                    mkBr(1, 1, fillAddr(2*k+1), 32'($urandom), 3'b0), 1'b1, 10'h000);
      stepCycle("rstFill");
    end
    applyStimulus(idle, idle, 1'b0, '0);
    sampleCycle("rstMid.before");
    checkEq("rstMid.beforeConst", 64'(bus.btbWE), 64'(1));
    #2 rst = 1'b1;
    #1 checkOutput("rstMid.async");
    checkEq("rstMid.asyncConst", 64'(bus.btbWE), 64'(0));
    advance();
    stepCycle("rstMid.held");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sampleCycle("rstMid.after");
      checkEq("rstMid.afterConst", 64'(bus.btbWE), 64'(0));
      advance();
    end
    applyStimulus(mkBr(1, 1, 32'h4000_0044, 32'h4000_0400, 3'b011), idle, 1'b0, '0);
    stepCycle("rstMid.new");
    applyStimulus(idle, idle, 1'b0, '0);
    stepCycle("rstMid.newWr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers branch-target updates from the integer execution pipes and writes them into the BTB's single write port one per cycle. It is the writer end of the BTB: execute produces `BranchResult`, this block converts taken branches into `BTB_Entry` records and defers each write until the fetch-side BTB read does not collide with it in the same bank. It sits between the integer execute stage and the BTB array in the fetch unit.

## Interface
Parameters:
- `UPDATE_WIDTH`, default `INT_ISSUE_WIDTH`: number of branch results accepted per cycle.
- `QUEUE_SIZE`, default `BTB_QUEUE_SIZE` (32): FIFO depth; must be a power of two.
- `BANK_BIT_WIDTH`, default `$clog2(FETCH_WIDTH)`: number of low BTB index bits that select the bank.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; asynchronous and active-high.
- `brResult[UPDATE_WIDTH]`  in  `BranchResult`  executed branch results.
- `fetchRE`  in  1  the BTB read port is active this cycle.
- `fetchIndex`  in  `BTB_IndexPath`  BTB index read this cycle.
- `btbWE`  out  1  BTB write enable.
- `btbWA`  out  `BTB_IndexPath`  BTB write index.
- `btbWV`  out  `BTB_Entry`  BTB write data.
- `full`  out  1  free slots are fewer than `UPDATE_WIDTH`.
- `overflow`  out  1  at least one qualifying result was dropped this cycle.

## Operation
- **Qualify.** A lane qualifies when `valid && execTaken`. Not-taken results never enter the queue.
- **Entry construction.** `wa = brAddr`. `wv.valid = 1`, `wv.tag = ToBTB_Tag(brAddr)`, `wv.data = ToBTB_Addr(nextAddr)`. `isCondBr`, `isRASPushBr` and `isRASPopBr` are copied unchanged.
- **Enqueue.**
  - Qualifying lanes are compacted in ascending lane order and written at `tail`, `tail+1`, and so on.
  - Capacity is the free-slot count at the start of the cycle, plus 1 if a dequeue happens in the same cycle.
  - Lanes beyond capacity are dropped, lowest lanes win, and `overflow` is asserted. Dropping is acceptable because the BTB is only a hint.
- **Dequeue.**
  - Occurs when the queue is non-empty and there is no conflict.
  - Conflict is `fetchRE && (ToBTB_Index(head.wa)[BANK_BIT_WIDTH-1:0] == fetchIndex[BANK_BIT_WIDTH-1:0])`.
  - When `BANK_BIT_WIDTH == 0`, any `fetchRE` is a conflict.
  - On dequeue: `btbWE = 1`, `btbWA = ToBTB_Index(head.wa)`, `btbWV = head.wv`, and `head` advances by 1.
- **Pointers.** `head` and `tail` are `BTBQueuePointerPath` and wrap modulo `QUEUE_SIZE`. `count` is `$clog2(QUEUE_SIZE)+1` bits wide. Each cycle, `count_next = count + enq_n - deq`.
- **Empty/full.** Empty is `count == 0`. `full` is `QUEUE_SIZE - count < UPDATE_WIDTH`, computed from registered state.
- **Ordering.** Strict FIFO. Two updates to the same index are both written, in order, so the last one wins.
- **No flush input.** Wrong-path results that reach execute are still written.
- **No enqueue-to-write bypass.** An entry enqueued in a cycle cannot be dequeued in that same cycle.

## Timing
- `btbWE`, `btbWA`, `btbWV` and `overflow` are combinational from registered state plus `fetchRE`, `fetchIndex` and `brResult`. The BTB samples them at the next edge.
- Minimum latency: a result presented in cycle N produces a write in cycle N+1 if the queue was empty and there is no conflict.
- Steady-state drain is 1 entry per cycle. A conflict stalls the head for that cycle only; there is no starvation counter.
- **Reset (asynchronous, `rst = 1`):**
  - `head = tail = count = 0`.
  - While `rst` is asserted: `btbWE = 0`, `overflow = 0`, `full = 0`, `btbWA = 0`, `btbWV = 0`.
  - Queue storage is not cleared. It is unreachable while `count == 0`.
- **Reset mid-operation:** all pending entries are discarded. No BTB write occurs in the reset cycle or the cycle after deassertion.
- **Wrap:** when `tail = QUEUE_SIZE-1` and two lanes qualify, they are written to slots 31 and 0.
- **Simultaneous full, enqueue and dequeue:** the slot freed by the dequeue is reusable in the same cycle. `full` reflects registered `count` only.

## Structure
- Already present in `FetchUnitTypes`: `BTBQueueEntry`, `BTBQueuePointerPath`, `BTB_QUEUE_SIZE` and the `ToBTB_*` helpers.
- Add `IsBTB_BankConflict(BTB_IndexPath a, BTB_IndexPath b)` to `FetchUnitTypes`, mirroring `IsBankConflict`.
- One sub-module: `btb_update_queue_storage`, a `QUEUE_SIZE × BTBQueueEntry` RAM with `UPDATE_WIDTH` write ports and 1 asynchronous read port. Pointer and count logic lives in the top module.

## Test plan
- **Single update.** Reset, then `brResult[0]` valid and taken with `brAddr = 0x1000_0040`, `nextAddr = 0x1000_0100`, `fetchRE = 0`. Required next cycle: `btbWE = 1`, `btbWA = ToBTB_Index(0x1000_0040)`, `btbWV.data = ToBTB_Addr(0x1000_0100)`, `btbWV.valid = 1`.
- **Not-taken filter.** A valid result with `execTaken = 0` → `btbWE` stays 0 for 3 cycles and `count` stays 0.
- **Bank conflict.** One entry queued with index bank 0; hold `fetchRE = 1` with `fetchIndex` bank 0 for 3 cycles, then bank 1. Required: no write for 3 cycles, then a write in the 4th.
- **Fill, overflow, wrap.** Keep `fetchRE` conflicting and enqueue 2 per cycle for 16 cycles: `full = 1` once `count ≥ 31`. A 17th pair → `overflow = 1` and both lanes dropped. Release the conflict: exactly 32 writes in FIFO order; `tail` wraps and a following pair lands at slots 0 and 1.
- **Enqueue plus dequeue at 31/32.** `count = 31`, head drains while 2 lanes qualify → both accepted, `count = 32`, `overflow = 0`.
- **Reset mid-drain.** 10 entries pending; assert `rst` asynchronously mid-cycle → `btbWE` drops immediately, and after release no writes occur until a new result arrives.
